// File: rtl/s208_state_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : s208_state_ctr
//  Description : s208 state holder. Eight state bits Y_1..Y_8 advanced as an
//                8-bit up-counter with synchronous Clear, registered
//                terminal-count and wrap flags, and a valid/ready snapshot
//                port with a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module s208_state_ctr #(
  parameter int                WIDTH    = 8,      // only 8 maps onto Y_1..Y_8
  parameter logic [WIDTH-1:0]  TC_VALUE = 8'hFF
) (
  input  logic             CK,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Enable,
  output logic             Y_1,
  output logic             Y_2,
  output logic             Y_3,
  output logic             Y_4,
  output logic             Y_5,
  output logic             Y_6,
  output logic             Y_7,
  output logic             Y_8,
  output logic             tc,
  output logic             wrap,
  input  logic             snap_req,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [WIDTH-1:0] snap_data,
  output logic             snap_overrun
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } snap_state_t;

  logic [1:0]       r_sync_q;
  logic             w_run;

  logic [WIDTH-1:0] r_cnt_q;
  logic [WIDTH-1:0] w_cnt_d;
  logic [WIDTH:0]   w_sum;
  logic             r_tc_q;
  logic             w_tc_d;
  logic             r_wrap_q;
  logic             w_wrap_d;

  snap_state_t      r_state_q;
  snap_state_t      w_state_d;
  logic [WIDTH-1:0] r_data_q;
  logic [WIDTH-1:0] w_data_d;
  logic             r_ovr_q;
  logic             w_ovr_d;

  // Reset deassertion synchroniser; assertion stays asynchronous.
  always_ff @(posedge CK or posedge Reset) begin
    if (Reset) begin
      r_sync_q <= 2'b00;
    end else begin
      r_sync_q <= {r_sync_q[0], 1'b1};
    end
  end

  // The datapath is released as soon as the first stage has seen the
  // deassertion, so the first state change lands on the 2nd edge.
  assign w_run = (r_sync_q != 2'b00);

  // Counter next state: Clear beats Enable; carry out of the MSB is the wrap.
  always_comb begin
    w_sum    = {1'b0, r_cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    w_cnt_d  = r_cnt_q;
    w_wrap_d = 1'b0;
    w_tc_d   = (r_cnt_q == TC_VALUE) && !Clear;
    if (Clear) begin
      w_cnt_d = '0;
    end else if (Enable) begin
      w_cnt_d  = w_sum[WIDTH-1:0];
      w_wrap_d = w_sum[WIDTH];
    end
  end

  // Counter, terminal-count and wrap registers.
  always_ff @(posedge CK or posedge Reset) begin
    if (Reset) begin
      r_cnt_q  <= '0;
      r_tc_q   <= 1'b0;
      r_wrap_q <= 1'b0;
    end else if (w_run) begin
      r_cnt_q  <= w_cnt_d;
      r_tc_q   <= w_tc_d;
      r_wrap_q <= w_wrap_d;
    end
  end

  // Snapshot FSM next state: capture the pre-update count; a request that
  // arrives while holding unaccepted data is dropped and flagged.
  always_comb begin
    w_state_d = r_state_q;
    w_data_d  = r_data_q;
    w_ovr_d   = r_ovr_q;
    case (r_state_q)
      ST_IDLE: begin
        if (snap_req) begin
          w_data_d  = r_cnt_q;
          w_state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (snap_ready && snap_req) begin
          w_data_d = r_cnt_q;
        end else if (snap_ready) begin
          w_state_d = ST_IDLE;
        end else if (snap_req) begin
          w_ovr_d = 1'b1;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // Snapshot FSM state, captured data and sticky overrun registers.
  always_ff @(posedge CK or posedge Reset) begin
    if (Reset) begin
      r_state_q <= ST_IDLE;
      r_data_q  <= '0;
      r_ovr_q   <= 1'b0;
    end else if (w_run) begin
      r_state_q <= w_state_d;
      r_data_q  <= w_data_d;
      r_ovr_q   <= w_ovr_d;
    end
  end

  assign Y_1          = r_cnt_q[0];
  assign Y_2          = r_cnt_q[1];
  assign Y_3          = r_cnt_q[2];
  assign Y_4          = r_cnt_q[3];
  assign Y_5          = r_cnt_q[4];
  assign Y_6          = r_cnt_q[5];
  assign Y_7          = r_cnt_q[6];
  assign Y_8          = r_cnt_q[7];
  assign tc           = r_tc_q;
  assign wrap         = r_wrap_q;
  assign snap_valid   = (r_state_q == ST_HOLD);
  assign snap_data    = r_data_q;
  assign snap_overrun = r_ovr_q;

endmodule
`default_nettype wire
